// File: rtl/rvv_uop_sequencer.sv
// Expands one decoded vector ALU instruction into per-register uops across its
// LMUL register group, handling widening/narrowing operand stepping.
//
// state | meaning
// IDLE  | nothing in flight, instruction port open
// ISSUE | emitting uops of the current instruction
module rvv_uop_sequencer #(
  parameter int REGFILE_INDEX_WIDTH = 5,
  parameter int UOP_IDX_W           = 3,
  parameter int TAG_W               = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           inst_valid,
  output logic                           inst_ready,
  input  logic [2:0]                     inst_vlmul,
  input  logic                           inst_widen,
  input  logic                           inst_narrow,
  input  logic                           inst_vl_zero,
  input  logic [REGFILE_INDEX_WIDTH-1:0] inst_vd,
  input  logic [REGFILE_INDEX_WIDTH-1:0] inst_vs1,
  input  logic [REGFILE_INDEX_WIDTH-1:0] inst_vs2,
  input  logic [TAG_W-1:0]               inst_tag,
  output logic                           uop_valid,
  input  logic                           uop_ready,
  output logic [REGFILE_INDEX_WIDTH-1:0] uop_vd,
  output logic [REGFILE_INDEX_WIDTH-1:0] uop_vs1,
  output logic [REGFILE_INDEX_WIDTH-1:0] uop_vs2,
  output logic [UOP_IDX_W-1:0]           uop_index,
  output logic                           uop_last,
  output logic [TAG_W-1:0]               uop_tag,
  output logic                           illegal
);

  localparam int RW = REGFILE_INDEX_WIDTH;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
  state_t state_q, state_d;

  logic [1:0]           lmul_log;
  logic                 frac, code_ok, dbl, inst_illegal;
  logic [2:0]           shamt;
  logic [UOP_IDX_W:0]   uop_cnt;
  logic [UOP_IDX_W-1:0] inst_last_idx;

  always_comb begin
    lmul_log = 2'd0;
    frac     = 1'b0;
    code_ok  = 1'b1;
    case (inst_vlmul)
      3'b110, 3'b111: frac = 1'b1;
      3'b000:         lmul_log = 2'd0;
      3'b001:         lmul_log = 2'd1;
      3'b010:         lmul_log = 2'd2;
      3'b011:         lmul_log = 2'd3;
      default:        code_ok = 1'b0;
    endcase
  end

  // Fractional groups fit in one register even when the other EMUL doubles.
  assign dbl           = (inst_widen | inst_narrow) & ~frac;
  assign inst_illegal  = ~code_ok | (inst_widen & inst_narrow)
                       | ((inst_widen | inst_narrow) & (lmul_log == 2'd3));
  assign shamt         = {1'b0, lmul_log} + {2'b00, dbl};
  assign uop_cnt       = (UOP_IDX_W+1)'(1) << shamt;
  assign inst_last_idx = UOP_IDX_W'(uop_cnt - (UOP_IDX_W+1)'(1));

  logic accept, go, hs, adv;
  assign accept = inst_valid & inst_ready;
  assign go     = accept & ~inst_illegal & ~inst_vl_zero;
  assign hs     = uop_valid & uop_ready;
  assign adv    = ~accept & hs & ~uop_last;

  logic [RW-1:0]        st_vd, st_vs1, st_vs2;
  logic                 st_widen, st_narrow;
  logic [UOP_IDX_W-1:0] st_last_idx;

  logic [RW-1:0]        sel_vd, sel_vs1, sel_vs2;
  logic                 sel_widen, sel_narrow;
  logic [UOP_IDX_W-1:0] sel_last_idx, nxt_i, half;
  logic [RW-1:0]        i_off, half_off;

  assign sel_vd       = go ? inst_vd       : st_vd;
  assign sel_vs1      = go ? inst_vs1      : st_vs1;
  assign sel_vs2      = go ? inst_vs2      : st_vs2;
  assign sel_widen    = go ? inst_widen    : st_widen;
  assign sel_narrow   = go ? inst_narrow   : st_narrow;
  assign sel_last_idx = go ? inst_last_idx : st_last_idx;

  assign nxt_i    = go ? '0 : uop_index + UOP_IDX_W'(1);
  assign half     = (sel_widen | sel_narrow) ? (nxt_i >> 1) : nxt_i;
  assign i_off    = RW'(nxt_i);
  assign half_off = RW'(half);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                state_d = IDLE;
    else if (accept)          state_d = go ? ISSUE : IDLE;
    else if (hs && uop_last)  state_d = IDLE;
  end

  always_comb begin
    inst_ready = ~rst & ~flush & ((state_q == IDLE) | (uop_valid & uop_last & uop_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uop_valid   <= 1'b0;
      uop_vd      <= '0;
      uop_vs1     <= '0;
      uop_vs2     <= '0;
      uop_index   <= '0;
      uop_last    <= 1'b0;
      uop_tag     <= '0;
      illegal     <= 1'b0;
      st_vd       <= '0;
      st_vs1      <= '0;
      st_vs2      <= '0;
      st_widen    <= 1'b0;
      st_narrow   <= 1'b0;
      st_last_idx <= '0;
    end else begin
      illegal <= 1'b0;
      if (flush) begin
        uop_valid <= 1'b0;
      end else begin
        if (accept) begin
          illegal   <= inst_illegal;
          uop_valid <= go;
        end else if (hs && uop_last) begin
          uop_valid <= 1'b0;
        end
        if (go) begin
          st_vd       <= inst_vd;
          st_vs1      <= inst_vs1;
          st_vs2      <= inst_vs2;
          st_widen    <= inst_widen;
          st_narrow   <= inst_narrow;
          st_last_idx <= inst_last_idx;
          uop_tag     <= inst_tag;
        end
        if (go || adv) begin
          uop_vd    <= sel_vd  + (sel_narrow ? half_off : i_off);
          uop_vs1   <= sel_vs1 + half_off;
          uop_vs2   <= sel_vs2 + (sel_widen ? half_off : i_off);
          uop_index <= nxt_i;
          uop_last  <= (nxt_i == sel_last_idx);
        end
      end
    end
  end

endmodule
